// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives the ALU op code and operand selects, and counts retired instructions.
// Moore outputs come from the state; pc_en and ir_write also follow zero and
// mem_ready in the same cycle, and illegal_op follows the opcode in DECODE.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_op,
    output logic             alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_RTYPE_WB  = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_ITYPE_WB  = 4'd11
    } state_t;

    // Opcodes understood by the controller.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU op codes.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU operand-B selects.
    localparam logic [2:0] SRC_B_REG      = 3'b000;
    localparam logic [2:0] SRC_B_FOUR     = 3'b001;
    localparam logic [2:0] SRC_B_SEXT     = 3'b010;
    localparam logic [2:0] SRC_B_SEXT_SH2 = 3'b011;
    localparam logic [2:0] SRC_B_ZEXT     = 3'b100;

    // PC source selects.
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t           state_q;
    logic [CNT_W-1:0] retired_q;

    // Instruction classes, valid while the IR holds the current instruction.
    logic is_lw;
    logic is_sw;
    logic is_rtype;
    logic is_beq;
    logic is_branch;
    logic is_jump;
    logic is_itype;
    logic is_legal;

    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_rtype  = (opcode == OP_RTYPE) && (funct[5:3] == 3'b100);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_branch = is_beq || (opcode == OP_BNE);
    assign is_jump   = (opcode == OP_J);
    assign is_itype  = (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                       (opcode == OP_ANDI) || (opcode == OP_ORI)   ||
                       (opcode == OP_XORI);
    assign is_legal  = is_lw || is_sw || is_rtype || is_branch || is_jump || is_itype;

    // R-type ALU function, funct 0x20..0x27 selected by its low three bits.
    logic [3:0] r_alu_op;

    // Map R-type funct to the ALU op code.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (which would infer a latch).
        r_alu_op = ALU_ADD;
        case (funct[2:0])
            3'd0, 3'd1: r_alu_op = ALU_ADD;
            3'd2, 3'd3: r_alu_op = ALU_SUB;
            3'd4:       r_alu_op = ALU_AND;
            3'd5:       r_alu_op = ALU_OR;
            3'd6:       r_alu_op = ALU_XOR;
            3'd7:       r_alu_op = ALU_NOR;
            default:    r_alu_op = ALU_ADD;
        endcase
    end

    // I-type ALU function and immediate extension.
    logic [3:0] i_alu_op;
    logic [2:0] i_src_b;

    // Arithmetic immediates are sign-extended, logical ones zero-extended.
    always_comb begin
        i_alu_op = ALU_ADD;
        i_src_b  = SRC_B_SEXT;
        case (opcode)
            OP_ANDI: begin i_alu_op = ALU_AND; i_src_b = SRC_B_ZEXT; end
            OP_ORI:  begin i_alu_op = ALU_OR;  i_src_b = SRC_B_ZEXT; end
            OP_XORI: begin i_alu_op = ALU_XOR; i_src_b = SRC_B_ZEXT; end
            default: begin i_alu_op = ALU_ADD; i_src_b = SRC_B_SEXT; end
        endcase
    end

    // State sequencing and retired-instruction counting; reset abandons the instruction.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_lw || is_sw)  state_q <= S_MEM_ADDR;
                    else if (is_rtype)   state_q <= S_EXEC_R;
                    else if (is_branch)  state_q <= S_BRANCH;
                    else if (is_jump)    state_q <= S_JUMP;
                    else if (is_itype)   state_q <= S_EXEC_I;
                    else                 state_q <= S_FETCH;
                end
                S_MEM_ADDR: begin
                    state_q <= is_lw ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    if (mem_ready) state_q <= S_MEM_WB;
                end
                S_MEM_WRITE: begin
                    if (mem_ready) begin
                        state_q   <= S_FETCH;
                        retired_q <= retired_q + CNT_W'(1);
                    end
                end
                S_EXEC_R: state_q <= S_RTYPE_WB;
                S_EXEC_I: state_q <= S_ITYPE_WB;
                S_MEM_WB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_ITYPE_WB: begin
                    state_q   <= S_FETCH;
                    retired_q <= retired_q + CNT_W'(1);
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Ungated strobes; rst forces them low below.
    logic pc_en_raw;
    logic ir_write_raw;
    logic mem_read_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic illegal_raw;

    // Datapath controls for the current state.
    always_comb begin
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_src        = PC_ALU;
        iord          = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_en_raw     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRC_B_FOUR;
                ir_write_raw = mem_ready;
                pc_en_raw    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = SRC_B_SEXT_SH2;
                illegal_raw = ~is_legal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_SEXT;
            end
            S_MEM_READ: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
            end
            S_RTYPE_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_en_raw = is_beq ? zero : ~zero;
            end
            S_JUMP: begin
                pc_src    = PC_JUMP;
                pc_en_raw = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = i_src_b;
                alu_op    = i_alu_op;
            end
            S_ITYPE_WB: begin
                reg_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en      = pc_en_raw     & ~rst;
    assign ir_write   = ir_write_raw  & ~rst;
    assign mem_read   = mem_read_raw  & ~rst;
    assign mem_write  = mem_write_raw & ~rst;
    assign reg_write  = reg_write_raw & ~rst;
    assign illegal_op = illegal_raw   & ~rst;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule
